noise_level_meter: RTL and testbench

- Measures the amplitude of an incoming unsigned sample stream over fixed-length windows.
- Quantizes each window's peak into a 3-bit noise level and holds it with fast-attack / slow-decay behaviour.
- Sits directly upstream of the one-hot noise indicator stage: output s drives that stage's 3-bit select input unmodified.

---
 rtl/noise_meter_pkg.sv | 10 +
 rtl/noise_level_meter_peak_window.sv | 48 ++++
 rtl/noise_level_meter.sv | 75 +++++++
 tb/tb_noise_level_meter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/noise_meter_pkg.sv
// Shared types and constants for the noise level meter and its indicator stage.
package noise_meter_pkg;

    localparam int unsigned LEVEL_W = 3;

    typedef logic [LEVEL_W-1:0] level_t;

    localparam level_t MAX_LEVEL = 3'd7;

endpackage : noise_meter_pkg

// File: rtl/noise_level_meter_peak_window.sv
// Window counter and running peak; flags window close and the closing peak's level.
module noise_level_meter_peak_window
    import noise_meter_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned WIN_LEN  = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                close_c,
    output level_t              cand_c
);

    localparam int unsigned CNT_W = $clog2(WIN_LEN);

    logic [CNT_W-1:0]    win_cnt;
    logic [SAMPLE_W-1:0] peak;
    logic [SAMPLE_W-1:0] pk_c;
    logic                last_c;

    // Running max including the current sample, and the close condition.
    always_comb begin
        pk_c    = (sample > peak) ? sample : peak;
        last_c  = (win_cnt == CNT_W'(WIN_LEN - 1));
        close_c = sample_valid && !clr && last_c;
        cand_c  = pk_c[SAMPLE_W-1 -: LEVEL_W];
    end

    // Window counter and peak; both restart after the closing sample.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            win_cnt <= '0;
            peak    <= '0;
        end else if (sample_valid) begin
            if (last_c) begin
                win_cnt <= '0;
                peak    <= '0;
            end else begin
                win_cnt <= win_cnt + CNT_W'(1);
                peak    <= pk_c;
            end
        end
    end

endmodule : noise_level_meter_peak_window

// File: rtl/noise_level_meter.sv
// Windowed peak meter with fast-attack / slow-decay 3-bit level output.
module noise_level_meter
    import noise_meter_pkg::*;
#(
    parameter int unsigned SAMPLE_W  = 8,
    parameter int unsigned WIN_LEN   = 256,
    parameter int unsigned DECAY_WIN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                level_clr,
    output level_t              s,
    output logic                s_update,
    output logic                win_done
);

    // Width must stay at least 1 even when a single lower window decays.
    localparam int unsigned DECAY_W = (DECAY_WIN > 1) ? $clog2(DECAY_WIN) : 1;

    logic               close_c;
    level_t             cand_c;
    level_t             s_nxt;
    logic [DECAY_W-1:0] decay_cnt;
    logic [DECAY_W-1:0] decay_nxt;

    noise_level_meter_peak_window #(
        .SAMPLE_W (SAMPLE_W),
        .WIN_LEN  (WIN_LEN)
    ) u_peak_window (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (level_clr),
        .sample_valid (sample_valid),
        .sample       (sample),
        .close_c      (close_c),
        .cand_c       (cand_c)
    );

    // Hysteresis: jump up at once, step down one level after DECAY_WIN lower windows.
    always_comb begin
        s_nxt     = s;
        decay_nxt = decay_cnt;
        if (close_c) begin
            if (cand_c > s) begin
                s_nxt     = cand_c;
                decay_nxt = '0;
            end else if (cand_c == s) begin
                decay_nxt = '0;
            end else if (decay_cnt == DECAY_W'(DECAY_WIN - 1)) begin
                s_nxt     = s - LEVEL_W'(1);
                decay_nxt = '0;
            end else begin
                decay_nxt = decay_cnt + DECAY_W'(1);
            end
        end
    end

    // Output and decay registers; clear wins over any sample in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || level_clr) begin
            s         <= '0;
            decay_cnt <= '0;
            s_update  <= 1'b0;
            win_done  <= 1'b0;
        end else begin
            s         <= s_nxt;
            decay_cnt <= decay_nxt;
            s_update  <= close_c && (s_nxt != s);
            win_done  <= close_c;
        end
    end

endmodule : noise_level_meter

// File: tb/tb_noise_level_meter.sv
// Scoreboard bench: closes push expected level, a monitor checks on each pulse.
module tb_noise_level_meter;
    import noise_meter_pkg::*;

    typedef struct {
        int s;
        int upd;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       sample_valid;
    logic [7:0] sample;
    logic       level_clr;
    level_t     s;
    logic       s_update;
    logic       win_done;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    noise_level_meter #(
        .SAMPLE_W  (8),
        .WIN_LEN   (4),
        .DECAY_WIN (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .level_clr    (level_clr),
        .s            (s),
        .s_update     (s_update),
        .win_done     (win_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Present one accepted sample; when it closes a window, queue the expected result.
    task automatic send(input logic [7:0] d, input bit closes, input int es, input int eu);
        exp_t e;
        if (closes) begin
            e.s   = es;
            e.upd = eu;
            exp_q.push_back(e);
        end
        sample_valid = 1'b1;
        sample       = d;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic window(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] d, input int es, input int eu);
        send(a, 1'b0, 0, 0);
        send(b, 1'b0, 0, 0);
        send(c, 1'b0, 0, 0);
        send(d, 1'b1, es, eu);
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (win_done === 1'b1 || s_update === 1'b1)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_win_done", int'(win_done), 1);
                check("mon_s", int'(s), e.s);
                check("mon_s_update", int'(s_update), e.upd);
            end
        end
    end

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst_n        = 1'b0;
        level_clr    = 1'b0;
        sample_valid = 1'b1;
        sample       = 8'hFF;

        // Reset dominates valid full-scale samples
        repeat (2) @(posedge clk);
        #1;
        check("rst_s", int'(s), 0);
        check("rst_s_update", int'(s_update), 0);
        check("rst_win_done", int'(win_done), 0);
        rst_n        = 1'b1;
        sample_valid = 1'b0;

        // Attack straight to 200>>5 = 6
        window(8'd10, 8'd200, 8'd30, 8'd40, 6, 1);
        @(posedge clk);
        #1;
        check("t2_pulse_win_done_low", int'(win_done), 0);
        check("t2_pulse_s_update_low", int'(s_update), 0);
        check("t2_s_held", int'(s), 6);

        // Decay from 6 with cand 1 windows
        window(8'h20, 8'h10, 8'h00, 8'h05, 6, 0);
        window(8'h20, 8'h10, 8'h00, 8'h05, 5, 1);
        window(8'h20, 8'h10, 8'h00, 8'h05, 5, 0);
        check("t3_decay_cnt", int'(dut.decay_cnt), 1);

        // Equal-level window clears the pending decay
        window(8'hA0, 8'h10, 8'h00, 8'h05, 5, 0);
        check("t4_decay_cnt_cleared", int'(dut.decay_cnt), 0);
        window(8'h20, 8'h10, 8'h00, 8'h05, 5, 0);
        check("t4_s_no_step", int'(s), 5);

        // Clear mid-window with a valid sample present
        send(8'h01, 1'b0, 0, 0);
        send(8'h02, 1'b0, 0, 0);
        level_clr    = 1'b1;
        sample_valid = 1'b1;
        sample       = 8'hFF;
        @(posedge clk);
        #1;
        level_clr    = 1'b0;
        sample_valid = 1'b0;
        check("t5_s_cleared", int'(s), 0);
        check("t5_no_s_update", int'(s_update), 0);
        check("t5_no_win_done", int'(win_done), 0);

        // Sparse valid: close only on the 4th accepted sample
        send(8'hFF, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        send(8'h00, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        send(8'h00, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_early_close", int'(win_done), 0);
        send(8'h00, 1'b1, 7, 1);
        @(posedge clk);
        #1;
        check("t6_s_final", int'(s), 7);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_noise_level_meter
